seg_to_stream_rx: RTL and testbench

- Receive-side counterpart of the segmented test source.
- Accepts one wide segmented beat: SEG_NUM segments of 64 bits, each with sop/eop/dval, a 4-bit packet number and a 12-bit zero count.
- Serialises each beat back into the 64-bit sop/eop/dval/mod/dout stream, one segment per accepted output slot.
- Checks segment protocol and reports sticky errors. Used in benches to close the loop on the segmented CRC path and compare against the original stream.

---
 rtl/seg_to_stream_rx.sv | 117 +++++++++++
 tb/tb_seg_to_stream_rx.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_to_stream_rx.sv
// seg_to_stream_rx: serialises segmented beats (top segment first) into a 64-bit stream and checks segment protocol; define SEG_RX_BIT_REVERSE_EN to reverse bits within each output byte
module seg_to_stream_rx #(
    parameter int SEG_NUM = 64,
    parameter int SEG_W = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SEG_NUM-1:0]       in_seg_sop,
    input  logic [SEG_NUM-1:0]       in_seg_eop,
    input  logic [SEG_NUM-1:0]       in_seg_dval,
    input  logic [4*SEG_NUM-1:0]     in_seg_packet_num,
    input  logic [12*SEG_NUM-1:0]    in_seg_zero_num,
    input  logic [SEG_W*SEG_NUM-1:0] in_seg_dout,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic                     out_sop,
    output logic                     out_eop,
    output logic                     out_dval,
    output logic [2:0]               out_mod,
    output logic [SEG_W-1:0]         out_dout,
    output logic [3:0]               err_flags,
    output logic [31:0]              pkt_cnt
);
    localparam int IW = $clog2(SEG_NUM);
    typedef enum logic {EMPTY, RUN} state_t;
    state_t state, state_d;
    logic [IW-1:0] seg_idx;
    logic [SEG_NUM-1:0] a_sop, a_eop, a_dval, s_sop, s_eop, s_dval;
    logic [4*SEG_NUM-1:0] a_pnum, s_pnum;
    logic [12*SEG_NUM-1:0] a_znum, s_znum;
    logic [SEG_W*SEG_NUM-1:0] a_dout, s_dout;
    logic skid_full, in_pkt, acc, fire, last, load_in, load_skid, fill_skid;
    logic [3:0] exp_pnum, c_pnum;
    logic [11:0] c_znum;
    logic c_sop, c_eop, c_dval;
    logic [SEG_W-1:0] c_dout, d_fix;

    assign in_ready  = !skid_full;
    assign acc       = in_valid && in_ready;
    assign out_valid = state == RUN;
    assign fire      = out_valid && out_ready;
    assign last      = fire && seg_idx == '0;
    assign load_in   = acc && (state == EMPTY || (last && !skid_full));
    assign load_skid = last && skid_full;
    assign fill_skid = acc && state == RUN && !last;

    assign c_sop  = a_sop[seg_idx];
    assign c_eop  = a_eop[seg_idx];
    assign c_dval = a_dval[seg_idx];
    assign c_pnum = a_pnum[4*seg_idx +: 4];
    assign c_znum = a_znum[12*seg_idx +: 12];
    assign c_dout = a_dout[SEG_W*seg_idx +: SEG_W];

`ifdef SEG_RX_BIT_REVERSE_EN
    always_comb begin
        for (int b = 0; b < SEG_W/8; b++)
            for (int i = 0; i < 8; i++)
                d_fix[8*b+i] = c_dout[8*b+7-i];
    end
`else
    assign d_fix = c_dout;
`endif

    // outputs are forced to zero whenever nothing is presented
    assign out_sop  = out_valid && c_sop;
    assign out_eop  = out_valid && c_eop;
    assign out_dval = out_valid && c_dval;
    assign out_mod  = (out_valid && c_eop) ? 3'(4'd8 - {1'b0, c_znum[2:0]}) : 3'd0;
    assign out_dout = out_valid ? d_fix : '0;

    always_comb begin
        state_d = state;
        state_d = (state == EMPTY) ? (acc ? RUN : EMPTY)
                                   : ((last && !skid_full && !acc) ? EMPTY : RUN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= EMPTY;
            seg_idx   <= '0;
            skid_full <= 1'b0;
            in_pkt    <= 1'b0;
            exp_pnum  <= 4'd1;
            err_flags <= 4'd0;
            pkt_cnt   <= 32'd0;
        end else begin
            state     <= state_d;
            seg_idx   <= (load_in || load_skid) ? '1 : (fire ? seg_idx - 1'b1 : seg_idx);
            skid_full <= fill_skid ? 1'b1 : (load_skid ? 1'b0 : skid_full);
            if (fire) begin
                if (c_sop && in_pkt) err_flags[0] <= 1'b1;
                if ((c_eop || c_dval) && !in_pkt && !c_sop) err_flags[1] <= 1'b1;
                if (c_eop && c_znum[11:3] != 9'(seg_idx)) err_flags[2] <= 1'b1;
                if (c_dval && c_pnum != exp_pnum) err_flags[3] <= 1'b1;
                if (c_eop) begin
                    pkt_cnt  <= pkt_cnt + 32'd1;
                    exp_pnum <= (exp_pnum == 4'd8) ? 4'd1 : exp_pnum + 4'd1;
                end
                in_pkt <= c_eop ? 1'b0 : (c_sop || in_pkt);
            end
        end
    end

    // beat storage needs no reset: its contents are only seen while in RUN
    always_ff @(posedge clk) begin
        if (load_in)
            {a_sop, a_eop, a_dval, a_pnum, a_znum, a_dout} <= {in_seg_sop, in_seg_eop, in_seg_dval,
                in_seg_packet_num, in_seg_zero_num, in_seg_dout};
        else if (load_skid)
            {a_sop, a_eop, a_dval, a_pnum, a_znum, a_dout} <= {s_sop, s_eop, s_dval, s_pnum, s_znum, s_dout};
        if (fill_skid)
            {s_sop, s_eop, s_dval, s_pnum, s_znum, s_dout} <= {in_seg_sop, in_seg_eop, in_seg_dval,
                in_seg_packet_num, in_seg_zero_num, in_seg_dout};
    end
endmodule

// File: tb/tb_seg_to_stream_rx.sv
// tb_seg_to_stream_rx: directed beats checked against a segment-queue model of the serialised stream
module tb_seg_to_stream_rx;
    localparam int N = 64;
    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic in_ready, out_valid, out_sop, out_eop, out_dval;
    logic [2:0] out_mod;
    logic [63:0] out_dout;
    logic [3:0] err_flags;
    logic [31:0] pkt_cnt;
    logic [N-1:0] b_sop, b_eop, b_dval;
    logic [4*N-1:0] b_pnum;
    logic [12*N-1:0] b_znum;
    logic [64*N-1:0] b_dout;

    typedef struct {
        logic sop, eop, dval;
        logic [3:0] pnum;
        logic [11:0] znum;
        logic [63:0] dout;
        int idx;
    } seg_t;
    seg_t q[$];

    int total = 0, bad = 0, fires = 0, dval_fires = 0, ir_low = 0, run_len = 0, max_run = 0, rdy_mode = 0;
    logic [2:0] last_eop_mod = 3'd7;
    bit armed = 0, m_in_pkt = 0;
    logic [3:0] m_err = 4'd0, m_exp = 4'd1;
    logic [31:0] m_cnt = 32'd0;

    seg_to_stream_rx dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_seg_sop(b_sop), .in_seg_eop(b_eop), .in_seg_dval(b_dval),
        .in_seg_packet_num(b_pnum), .in_seg_zero_num(b_znum), .in_seg_dout(b_dout),
        .out_ready(out_ready), .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
        .out_dval(out_dval), .out_mod(out_mod), .out_dout(out_dout),
        .err_flags(err_flags), .pkt_cnt(pkt_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] seg_data(input int seed, input int k);
        return {16'(seed), 8'(k), 8'hA5, 32'(32'h9E3779B9 * (k + 1 + seed))};
    endfunction

    function automatic logic [63:0] exp_dout(input logic [63:0] d);
`ifdef SEG_RX_BIT_REVERSE_EN
        logic [63:0] r;
        for (int b = 0; b < 8; b++)
            for (int i = 0; i < 8; i++)
                r[8*b+i] = d[8*b+7-i];
        return r;
`else
        return d;
`endif
    endfunction

    task automatic clear_beat(input int seed);
        b_sop = '0; b_eop = '0; b_dval = '0; b_pnum = '0; b_znum = '0;
        for (int k = 0; k < N; k++) b_dout[64*k +: 64] = seg_data(seed, k);
    endtask

    task automatic set_seg(input int k, input logic s, input logic e, input logic v,
                           input logic [3:0] p, input logic [11:0] z);
        b_sop[k] = s; b_eop[k] = e; b_dval[k] = v;
        b_pnum[4*k +: 4] = p; b_znum[12*k +: 12] = z;
    endtask

    // an 8-word packet in segments 63..56, padded by 56 idle segments
    task automatic pkt_beat(input logic [3:0] p, input int seed);
        clear_beat(seed);
        for (int k = 63; k >= 56; k--) set_seg(k, k == 63, k == 56, 1'b1, p, (k == 56) ? 12'd448 : 12'd0);
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic send();
        bit ok = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            step();
        end
        in_valid = 1'b0;
        chk("accept", ok, 1);
    endtask

    task automatic rst_pulse();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic settle(input logic [3:0] e_err, input logic [31:0] e_cnt);
        int n = 0;
        while ((q.size() != 0 || out_valid) && n < 3000) begin
            step();
            n++;
        end
        chk("drain", n < 3000, 1);
        @(negedge clk);
        chk("idle_valid", out_valid, 0);
        chk("lit_err", err_flags, e_err);
        chk("lit_cnt", pkt_cnt, e_cnt);
        step();
    endtask

    always @(posedge clk) begin
        #1;
        out_ready = (rdy_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        seg_t e;
        if (armed) begin
            chk("out_valid", out_valid, q.size() != 0);
            chk("err_flags", err_flags, m_err);
            chk("pkt_cnt", pkt_cnt, m_cnt);
            if (out_valid && q.size() != 0) begin
                e = q[0];
                chk("sop", out_sop, e.sop);
                chk("eop", out_eop, e.eop);
                chk("dval", out_dval, e.dval);
                chk("mod", out_mod, e.eop ? 3'(8 - e.znum[2:0]) : 3'd0);
                chk("dout", out_dout, exp_dout(e.dout));
            end
            if (!in_ready) ir_low++;
            run_len = out_valid ? run_len + 1 : 0;
            if (run_len > max_run) max_run = run_len;
        end
        if (!rst_n) begin
            q.delete();
            m_err = 4'd0; m_exp = 4'd1; m_cnt = 32'd0; m_in_pkt = 0;
            armed = 1;
        end else if (armed) begin
            if (out_valid && out_ready && q.size() != 0) begin
                e = q.pop_front();
                fires++;
                if (e.dval) dval_fires++;
                if (e.sop && m_in_pkt) m_err[0] = 1'b1;
                if ((e.eop || e.dval) && !m_in_pkt && !e.sop) m_err[1] = 1'b1;
                if (e.eop && int'(e.znum / 8) != e.idx) m_err[2] = 1'b1;
                if (e.dval && e.pnum != m_exp) m_err[3] = 1'b1;
                if (e.eop) begin
                    last_eop_mod = out_mod;
                    m_cnt++;
                    m_exp = (m_exp == 4'd8) ? 4'd1 : m_exp + 4'd1;
                    m_in_pkt = 0;
                end else if (e.sop) m_in_pkt = 1;
            end
            if (in_valid && in_ready)
                for (int k = N - 1; k >= 0; k--)
                    q.push_back('{b_sop[k], b_eop[k], b_dval[k], b_pnum[4*k +: 4],
                                  b_znum[12*k +: 12], b_dout[64*k +: 64], k});
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        clear_beat(0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_err", err_flags, 0);
        chk("rst_cnt", pkt_cnt, 0);
        chk("rst_dout", out_dout, 0);
        chk("rst_mod", out_mod, 0);
        step();

        // single 8-word packet then 56 idle slots
        fires = 0; dval_fires = 0; last_eop_mod = 3'd7;
        pkt_beat(4'd1, 1);
        send();
        chk("t1_first_valid", out_valid, 1);
        chk("t1_first_sop", out_sop, 1);
        chk("t1_first_dout", out_dout, exp_dout(seg_data(1, 63)));
        settle(4'd0, 32'd1);
        chk("t1_fires", fires, 64);
        chk("t1_dval_slots", dval_fires, 8);
        chk("t1_mod", last_eop_mod, 0);

        // single-word packet ending in segment 10 with one valid byte
        last_eop_mod = 3'd7;
        clear_beat(2);
        set_seg(10, 1'b1, 1'b1, 1'b1, 4'd2, 12'd87);
        send();
        settle(4'd0, 32'd2);
        chk("t2_mod", last_eop_mod, 1);

        // three back-to-back beats: no output bubble
        ir_low = 0; max_run = 0;
        pkt_beat(4'd3, 3); send();
        pkt_beat(4'd4, 4); send();
        pkt_beat(4'd5, 5); send();
        settle(4'd0, 32'd5);
        chk("t3_run", max_run, 192);
        chk("t3_ready_low", ir_low, 126);

        // random backpressure, packet number wraps 8 -> 1
        rdy_mode = 1;
        pkt_beat(4'd6, 6); send();
        pkt_beat(4'd7, 7); send();
        pkt_beat(4'd8, 8); send();
        pkt_beat(4'd1, 9); send();
        rdy_mode = 0;
        settle(4'd0, 32'd9);

        // protocol errors: sop in packet, bad zero count, bad packet number
        rst_pulse();
        clear_beat(10);
        for (int k = 63; k >= 60; k--) set_seg(k, k == 63, k == 60, 1'b1, 4'd1, (k == 60) ? 12'd480 : 12'd0);
        for (int k = 59; k >= 56; k--) set_seg(k, k == 59 || k == 58, k == 56, 1'b1, 4'd3, (k == 56) ? 12'd447 : 12'd0);
        send();
        settle(4'b1101, 32'd2);
        rst_pulse();
        @(negedge clk);
        chk("t5_err_clr", err_flags, 0);
        chk("t5_cnt_clr", pkt_cnt, 0);
        step();

        // reset in the middle of a beat
        pkt_beat(4'd1, 11);
        send();
        repeat (33) step();
        chk("t6_seg30", out_dout, exp_dout(seg_data(11, 30)));
        rst_pulse();
        @(negedge clk);
        chk("t6_valid", out_valid, 0);
        chk("t6_ready", in_ready, 1);
        chk("t6_outs", {out_sop, out_eop, out_dval, out_mod}, 0);
        chk("t6_dout", out_dout, 0);
        chk("t6_err", err_flags, 0);
        chk("t6_cnt", pkt_cnt, 0);
        step();
        pkt_beat(4'd1, 12);
        send();
        chk("t6_restart_sop", out_sop, 1);
        chk("t6_restart_dout", out_dout, exp_dout(seg_data(12, 63)));
        settle(4'd0, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
